// File: rtl/cordic_iter_ctrl.sv
// Purpose : iteration sequencer for the single-step cordic stage (operand latch, x/y/z/d loop, arctan ROM, result hold).
// Latency : start accepted at edge k -> o_done visible after edge k+p_ITERATIONS (sampled high at edge k+p_ITERATIONS+1).
// Backpr. : o_ready gates i_start; i_start and operands are ignored while o_busy is high.
// Ports   : i_clk/i_rstn (sync, active low); i_start/i_mode/i_x/i_y/i_z operand request;
//           o_ready/o_busy/o_done status; o_x/o_y/o_z held results;
//           o_xprev/o_yprev/o_zprev/o_dprev/o_mode/o_lut/o_shift_amnt feed the stage,
//           i_xnext/i_ynext/i_znext/i_dnext come back from it.
module cordic_iter_ctrl #(
    parameter int p_WIDTH      = 32,
    parameter int p_ITERATIONS = 10
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic [p_WIDTH-1:0] i_x,
    input  logic [p_WIDTH-1:0] i_y,
    input  logic [p_WIDTH-1:0] i_z,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [p_WIDTH-1:0] o_x,
    output logic [p_WIDTH-1:0] o_y,
    output logic [p_WIDTH-1:0] o_z,
    output logic [p_WIDTH-1:0] o_xprev,
    output logic [p_WIDTH-1:0] o_yprev,
    output logic [p_WIDTH-1:0] o_zprev,
    output logic               o_dprev,
    output logic               o_mode,
    output logic [p_WIDTH-1:0] o_lut,
    output logic [4:0]         o_shift_amnt,
    input  logic [p_WIDTH-1:0] i_xnext,
    input  logic [p_WIDTH-1:0] i_ynext,
    input  logic [p_WIDTH-1:0] i_znext,
    input  logic               i_dnext
);

    localparam logic [4:0] LP_LAST = 5'(p_ITERATIONS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [p_WIDTH-1:0] r_x, r_y, r_z;
    logic [p_WIDTH-1:0] r_xout, r_yout, r_zout;
    logic               r_d, r_mode;
    logic [4:0]         r_shift;
    logic               r_ready, r_busy, r_done;
    logic [31:0]        w_rom;

    // r_ready mirrors "state is IDLE or DONE", so it doubles as the accept qualifier.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_xout  <= '0;
            r_yout  <= '0;
            r_zout  <= '0;
            r_d     <= 1'b1;
            r_mode  <= 1'b0;
            r_shift <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_x     <= i_x;
                        r_y     <= i_y;
                        r_z     <= i_z;
                        r_mode  <= i_mode;
                        // First rotation direction follows the sign of the requested angle.
                        r_d     <= ~i_z[p_WIDTH-1];
                        r_shift <= '0;
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_x <= i_xnext;
                    r_y <= i_ynext;
                    r_z <= i_znext;
                    r_d <= i_dnext;
                    if (r_shift == LP_LAST) begin
                        r_xout  <= i_xnext;
                        r_yout  <= i_ynext;
                        r_zout  <= i_znext;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_shift <= r_shift + 5'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // atan(2^-i) scaled so that 2^31 represents pi.
    always_comb begin
        w_rom = 32'h0000_0000;
        case (r_shift)
            5'd0:  w_rom = 32'h2000_0000;
            5'd1:  w_rom = 32'h12E4_051D;
            5'd2:  w_rom = 32'h09FB_385B;
            5'd3:  w_rom = 32'h0511_11D4;
            5'd4:  w_rom = 32'h028B_0D43;
            5'd5:  w_rom = 32'h0145_D7E1;
            5'd6:  w_rom = 32'h00A2_F61E;
            5'd7:  w_rom = 32'h0051_7C55;
            5'd8:  w_rom = 32'h0028_BE53;
            5'd9:  w_rom = 32'h0014_5F2E;
            5'd10: w_rom = 32'h000A_2F98;
            5'd11: w_rom = 32'h0005_17CC;
            5'd12: w_rom = 32'h0002_8BE6;
            5'd13: w_rom = 32'h0001_45F3;
            5'd14: w_rom = 32'h0000_A2FA;
            5'd15: w_rom = 32'h0000_517D;
            5'd16: w_rom = 32'h0000_28BE;
            5'd17: w_rom = 32'h0000_145F;
            5'd18: w_rom = 32'h0000_0A30;
            5'd19: w_rom = 32'h0000_0518;
            5'd20: w_rom = 32'h0000_028C;
            5'd21: w_rom = 32'h0000_0146;
            5'd22: w_rom = 32'h0000_00A3;
            5'd23: w_rom = 32'h0000_0051;
            5'd24: w_rom = 32'h0000_0029;
            5'd25: w_rom = 32'h0000_0014;
            5'd26: w_rom = 32'h0000_000A;
            5'd27: w_rom = 32'h0000_0005;
            5'd28: w_rom = 32'h0000_0003;
            5'd29: w_rom = 32'h0000_0001;
            5'd30: w_rom = 32'h0000_0001;
            5'd31: w_rom = 32'h0000_0000;
            default: w_rom = 32'h0000_0000;
        endcase
    end

    // Narrower datapaths keep the most significant ROM bits; wider ones zero-extend below.
    generate
        if (p_WIDTH <= 32) begin : g_lut_trunc
            assign o_lut = w_rom[31 -: p_WIDTH];
        end else begin : g_lut_pad
            assign o_lut = {w_rom, {(p_WIDTH - 32){1'b0}}};
        end
    endgenerate

    assign o_ready      = r_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_x          = r_xout;
    assign o_y          = r_yout;
    assign o_z          = r_zout;
    assign o_xprev      = r_x;
    assign o_yprev      = r_y;
    assign o_zprev      = r_z;
    assign o_dprev      = r_d;
    assign o_mode       = r_mode;
    assign o_shift_amnt = r_shift;

endmodule
